// File: rtl/sysbus_pkg.sv
// Shared Sysbus definitions: tag field layout, line geometry and the
// responder state encoding.
package sysbus_pkg;

   localparam int TAG_WIDTH      = 13;
   localparam int TAG_WRITE      = 12;
   localparam int TAG_TYPE_LSB   = 8;
   localparam int TAG_TYPE_WIDTH = 4;
   localparam int TAG_ID_LSB     = 0;
   localparam int TAG_ID_WIDTH   = 8;

   localparam int LINE_BEATS     = 8;
   localparam int LINE_BYTES     = 64;

   typedef enum logic [1:0] {
      IDLE,
      WR_DATA,
      RD_WAIT,
      RD_RESP
   } resp_state_e;

endpackage

// File: rtl/sysbus_mem_array.sv
// Backing word store for the Sysbus memory responder: combinational read,
// one synchronous write port.
module sysbus_mem_array #(
  parameter int DATA_WIDTH = 64,
  parameter int WORDS      = 4096,
  parameter int ADDR_WIDTH = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [WORDS];

  // No reset: contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory responder: line writes into a local array, line reads returned
// as tagged beats. Define SYSBUS_RESP_STALL_EN for LFSR-driven back-pressure.
module sysbus_mem_responder #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int MEM_WORDS      = 4096,
   parameter int LINE_BEATS     = 8,
   parameter int READ_LATENCY   = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      bus_reqcyc,
   output logic                      bus_reqack,
   input  logic [BUS_DATA_WIDTH-1:0] bus_req,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   output logic                      bus_respcyc,
   input  logic                      bus_respack,
   output logic [BUS_DATA_WIDTH-1:0] bus_resp,
   output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

   import sysbus_pkg::*;

   localparam int AW = $clog2(MEM_WORDS);
   localparam int BW = $clog2(LINE_BEATS);
   localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   resp_state_e               state, state_next;
   logic [BW-1:0]             beat, beat_next;
   logic [LW-1:0]             lat, lat_next;
   logic [AW-1:0]             base, base_next;
   logic                      reqack, reqack_next;
   logic                      respcyc, respcyc_next;
   logic [BUS_DATA_WIDTH-1:0] resp, resp_next;
   logic [BUS_TAG_WIDTH-1:0]  resptag, resptag_next;

   logic                      accept;
   logic                      stall;
   logic                      mem_we;
   logic [AW-1:0]             hdr_idx;
   logic [AW-1:0]             rd_idx;
   logic [BUS_DATA_WIDTH-1:0] rd_data;

   assign accept  = bus_reqcyc && reqack;
   // Word index of the line base: byte address / 8, beat bits cleared; wraps modulo MEM_WORDS.
   assign hdr_idx = {bus_req[AW+2:3+BW], {BW{1'b0}}};

`ifdef SYSBUS_RESP_STALL_EN
   logic [7:0] lfsr;

   always_ff @(posedge clk) begin
      if (reset) lfsr <= 8'hA5;
      else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   assign stall = lfsr[0];
`else
   assign stall = 1'b0;
`endif

   always_comb begin
      state_next   = state;
      beat_next    = beat;
      lat_next     = lat;
      base_next    = base;
      reqack_next  = 1'b0;
      respcyc_next = respcyc;
      resp_next    = resp;
      resptag_next = resptag;
      rd_idx       = base + AW'(beat);
      mem_we       = 1'b0;

      case (state)
         IDLE: begin
            respcyc_next = 1'b0;
            if (accept) begin
               base_next = hdr_idx;
               beat_next = '0;
               lat_next  = '0;
               if (bus_reqtag[TAG_WRITE]) begin
                  state_next  = WR_DATA;
                  reqack_next = !stall;
               end else begin
                  state_next   = RD_WAIT;
                  resptag_next = bus_reqtag;
               end
            end else begin
               reqack_next = bus_reqcyc && !reqack;
            end
         end

         WR_DATA: begin
            mem_we = accept;
            if (accept) begin
               if (beat == BW'(LINE_BEATS - 1)) begin
                  state_next = IDLE;
                  beat_next  = '0;
               end else begin
                  beat_next   = beat + 1'b1;
                  reqack_next = !stall;
               end
            end else begin
               reqack_next = bus_reqcyc && !stall;
            end
         end

         RD_WAIT: begin
            if (lat == LW'(READ_LATENCY - 1)) begin
               state_next   = RD_RESP;
               resp_next    = rd_data;
               respcyc_next = !stall;
            end else begin
               lat_next = lat + 1'b1;
            end
         end

         RD_RESP: begin
            if (respcyc && bus_respack) begin
               if (beat == BW'(LINE_BEATS - 1)) begin
                  state_next   = IDLE;
                  beat_next    = '0;
                  respcyc_next = 1'b0;
               end else begin
                  beat_next    = beat + 1'b1;
                  rd_idx       = base + AW'(beat) + AW'(1);
                  resp_next    = rd_data;
                  respcyc_next = !stall;
               end
            end else if (!respcyc) begin
               // Bubble cycle: data already loaded, present it now.
               respcyc_next = 1'b1;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         beat    <= '0;
         lat     <= '0;
         base    <= '0;
         reqack  <= 1'b0;
         respcyc <= 1'b0;
         resp    <= '0;
         resptag <= '0;
      end else begin
         state   <= state_next;
         beat    <= beat_next;
         lat     <= lat_next;
         base    <= base_next;
         reqack  <= reqack_next;
         respcyc <= respcyc_next;
         resp    <= resp_next;
         resptag <= resptag_next;
      end
   end

   sysbus_mem_array #(
      .DATA_WIDTH (BUS_DATA_WIDTH),
      .WORDS      (MEM_WORDS),
      .ADDR_WIDTH (AW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we && !reset),
      .waddr (base + AW'(beat)),
      .wdata (bus_req),
      .raddr (rd_idx),
      .rdata (rd_data)
   );

   assign bus_reqack  = reqack;
   assign bus_respcyc = respcyc;
   assign bus_resp    = resp;
   assign bus_resptag = resptag;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder: line write, read-back, response
// stall, address aliasing and reset during a read burst.
module tb_sysbus_mem_responder;

   localparam int READ_LATENCY = 4;
   localparam int MEM_WORDS    = 4096;

   logic        clk = 1'b0;
   logic        reset;
   logic        bus_reqcyc;
   logic        bus_reqack;
   logic [63:0] bus_req;
   logic [12:0] bus_reqtag;
   logic        bus_respcyc;
   logic        bus_respack;
   logic [63:0] bus_resp;
   logic [12:0] bus_resptag;

   int          n_total = 0;
   int          n_bad   = 0;
   int          cyc_cnt = 0;

   logic [63:0] wr_line  [8];
   logic [63:0] exp_line [8];

   sysbus_mem_responder #(
      .BUS_DATA_WIDTH (64),
      .BUS_TAG_WIDTH  (13),
      .MEM_WORDS      (MEM_WORDS),
      .LINE_BEATS     (8),
      .READ_LATENCY   (READ_LATENCY)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus_reqcyc  (bus_reqcyc),
      .bus_reqack  (bus_reqack),
      .bus_req     (bus_req),
      .bus_reqtag  (bus_reqtag),
      .bus_respcyc (bus_respcyc),
      .bus_respack (bus_respack),
      .bus_resp    (bus_resp),
      .bus_resptag (bus_resptag)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic do_write(input logic [63:0] addr, input logic [12:0] tag);
      int k     = 0;
      int acks  = 0;
      int resps = 0;
      bus_reqcyc = 1'b1;
      bus_req    = addr;
      bus_reqtag = tag;
      for (int c = 0; c < 100 && k < 9; c++) begin
         @(negedge clk);
         if (bus_respcyc) resps++;
         if (bus_reqack) begin
            acks++;
            k++;
            @(posedge clk);
            #1;
            if (k < 9) bus_req = wr_line[k-1];
            else       bus_reqcyc = 1'b0;
         end
      end
      repeat (4) begin
         @(negedge clk);
         if (bus_reqack)  acks++;
         if (bus_respcyc) resps++;
      end
      check("wr_done", 64'(k), 64'd9);
      check("wr_acks", 64'(acks), 64'd9);
      check("wr_no_resp", 64'(resps), 64'd0);
   endtask

   // stop_beat >= 0 leaves the burst parked on that beat (respack low) and returns.
   task automatic do_read(input logic [63:0] addr, input logic [12:0] tag,
                          input int stall_beat, input int stall_n, input int stop_beat);
      int  acc_edge = 0;
      int  b        = 0;
      int  hold     = 0;
      bit  got_hdr  = 1'b0;
      bit  first    = 1'b1;
      bit  done     = 1'b0;
      bus_reqcyc  = 1'b1;
      bus_req     = addr;
      bus_reqtag  = tag;
      bus_respack = 1'b1;
      for (int c = 0; c < 50 && !got_hdr; c++) begin
         @(negedge clk);
         if (bus_reqack) begin
            got_hdr  = 1'b1;
            acc_edge = cyc_cnt + 1;
            @(posedge clk);
            #1;
            bus_reqcyc = 1'b0;
         end
      end
      check("rd_hdr_ack", 64'(got_hdr), 64'd1);
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (bus_respcyc) begin
            if (first) begin
               check("rd_latency", 64'(cyc_cnt - acc_edge), 64'(READ_LATENCY));
               first = 1'b0;
            end
            check("rd_data", bus_resp, exp_line[b]);
            check("rd_tag", 64'(bus_resptag), 64'(tag));
            if (b == stop_beat) begin
               bus_respack = 1'b0;
               done        = 1'b1;
            end else if (b == stall_beat && hold < stall_n) begin
               bus_respack = 1'b0;
               hold++;
            end else begin
               bus_respack = 1'b1;
               b++;
               if (b == 8) done = 1'b1;
            end
         end
      end
      check("rd_done", 64'(done), 64'd1);
      if (stop_beat < 0) begin
         @(negedge clk);
         check("rd_end_drop", 64'(bus_respcyc), 64'd0);
         bus_respack = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      bus_reqcyc  = 1'b0;
      bus_req     = '0;
      bus_reqtag  = '0;
      bus_respack = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_reqack", 64'(bus_reqack), 64'd0);
      check("rst_respcyc", 64'(bus_respcyc), 64'd0);
      check("rst_resp", bus_resp, 64'd0);
      check("rst_resptag", 64'(bus_resptag), 64'd0);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("idle_no_ack", 64'(bus_reqack), 64'd0);
      end

      // Line at 0x1000: 0x11, 0x22, ... 0x88
      wr_line = '{64'h11, 64'h22, 64'h33, 64'h44, 64'h55, 64'h66, 64'h77, 64'h88};
      do_write(64'h1000, 13'h1005);

      exp_line = '{64'h11, 64'h22, 64'h33, 64'h44, 64'h55, 64'h66, 64'h77, 64'h88};
      do_read(64'h1008, 13'h0007, -1, 0, -1);

      do_read(64'h1000, 13'h0042, 3, 5, -1);

      // Line at 0x40, then read back through the aliased address MEM_WORDS*8 + 0x40
      wr_line = '{64'hC0DE_0000_0000_0001, 64'hC0DE_0000_0000_0002,
                  64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0004,
                  64'hC0DE_0000_0000_0005, 64'hC0DE_0000_0000_0006,
                  64'hC0DE_0000_0000_0007, 64'hC0DE_0000_0000_0008};
      do_write(64'h40, 13'h1101);
      exp_line = wr_line;
      do_read(64'h8040, 13'h0013, -1, 0, -1);

      // Reset while beat 4 of a read is on the bus
      exp_line = '{64'h11, 64'h22, 64'h33, 64'h44, 64'h55, 64'h66, 64'h77, 64'h88};
      do_read(64'h1038, 13'h00A9, -1, 0, 4);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_respcyc", 64'(bus_respcyc), 64'd0);
      check("midrst_resp", bus_resp, 64'd0);
      check("midrst_resptag", 64'(bus_resptag), 64'd0);
      check("midrst_reqack", 64'(bus_reqack), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      do_read(64'h1000, 13'h0055, -1, 0, -1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
